// File: rtl/cycle_interval_meter_pkg.sv
// Shared types for the cycle interval meter: FSM state encoding and default width.
package cycle_meter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } meter_state_t;

  localparam int DEFAULT_BIT_WIDTH = 16;

endpackage

// File: rtl/cycle_interval_meter_if.sv
// Control, result handshake and status bundle of the cycle interval meter.
interface cycle_interval_meter_if #(
  parameter int BIT_WIDTH = 16
);
  logic                 enable;
  logic                 clear;
  logic                 start;
  logic                 stop;
  logic [BIT_WIDTH-1:0] timeout_limit;
  logic [BIT_WIDTH-1:0] result_count;
  logic                 result_overflow;
  logic                 result_timeout;
  logic                 result_valid;
  logic                 result_ready;
  logic                 busy;
  logic                 missed_start;

  modport master (
    output enable, clear, start, stop, timeout_limit, result_ready,
    input  result_count, result_overflow, result_timeout, result_valid, busy, missed_start
  );

  modport slave (
    input  enable, clear, start, stop, timeout_limit, result_ready,
    output result_count, result_overflow, result_timeout, result_valid, busy, missed_start
  );
endinterface

// File: rtl/cycle_interval_meter_sat_up_counter.sv
// Saturating up-counter: load to 1, increment, sticks at all-ones and flags it.
module sat_up_counter #(
  parameter int BIT_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 i_clear,
  input  logic                 i_load,
  input  logic                 i_inc,
  output logic [BIT_WIDTH-1:0] o_count,
  output logic                 o_at_max
);
  logic [BIT_WIDTH-1:0] r_count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= BIT_WIDTH'(1);
    end else if (i_inc && !o_at_max) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_at_max = &r_count;
  assign o_count  = r_count;
endmodule

// File: rtl/cycle_interval_meter.sv
// Counts enabled cycles from start to stop (or timeout) and offers the result on a
// valid/ready port; the result is held until accepted and a new run may start on acceptance.
module cycle_interval_meter
  import cycle_meter_pkg::*;
#(
  parameter int BIT_WIDTH = DEFAULT_BIT_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset_n,
  cycle_interval_meter_if.slave meter
);
  typedef struct packed {
    logic [BIT_WIDTH-1:0] count;
    logic                 overflow;
    logic                 timeout;
  } meter_result_t;

  meter_state_t         r_state, w_next;
  meter_result_t        r_result, w_result;
  logic [BIT_WIDTH-1:0] r_limit, w_count;
  logic                 r_valid, r_busy, r_missed;
  logic                 w_at_max, w_load, w_inc, w_missed, w_handshake, w_idle_act;

  sat_up_counter #(.BIT_WIDTH(BIT_WIDTH)) u_counter (
    .clock    (clock),
    .reset_n  (reset_n),
    .i_clear  (meter.clear),
    .i_load   (w_load),
    .i_inc    (w_inc),
    .o_count  (w_count),
    .o_at_max (w_at_max)
  );

  // The handshake is deliberately not gated by enable.
  assign w_handshake = r_valid & meter.result_ready;

  always_comb begin
    w_next     = r_state;
    w_result   = r_result;
    w_load     = 1'b0;
    w_inc      = 1'b0;
    w_missed   = 1'b0;
    w_idle_act = 1'b0;
    if (meter.clear) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE: w_idle_act = meter.enable;
        RUN: if (meter.enable) begin
          if (meter.stop) begin
            w_next   = DONE;
            w_result = '{count: w_count, overflow: w_at_max, timeout: 1'b0};
            w_missed = meter.start;
          end else if (r_limit != '0 && w_count == r_limit) begin
            w_next   = DONE;
            w_result = '{count: r_limit, overflow: w_at_max, timeout: 1'b1};
          end else begin
            w_inc = 1'b1;
          end
        end
        DONE: begin
          if (w_handshake) begin
            w_next     = IDLE;
            w_idle_act = meter.enable;
          end else begin
            w_missed = meter.enable & meter.start;
          end
        end
        default: w_next = IDLE;
      endcase
      // Accepting a result behaves like IDLE in the same cycle, so runs can go back to back.
      if (w_idle_act) begin
        if (meter.start && meter.stop) begin
          w_next   = DONE;
          w_result = '0;
        end else if (meter.start) begin
          w_next = RUN;
          w_load = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_result <= '0;
      r_limit  <= '0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
      r_missed <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_result <= meter.clear ? '0 : w_result;
      r_limit  <= meter.clear ? '0 : (w_load ? meter.timeout_limit : r_limit);
      r_valid  <= (w_next == DONE);
      r_busy   <= (w_next == RUN);
      r_missed <= w_missed;
    end
  end

  assign meter.result_count    = r_result.count;
  assign meter.result_overflow = r_result.overflow;
  assign meter.result_timeout  = r_result.timeout;
  assign meter.result_valid    = r_valid;
  assign meter.busy            = r_busy;
  assign meter.missed_start    = r_missed;
endmodule
